led_frame_sequencer: RTL and testbench
======================================

// Module: led_frame_sequencer
// PURPOSE
//   Sequences the SPI LED matrix driver (MAX7219-class, 16-bit command words).
//   After reset it sends the power-up init word list, then refreshes 8 row registers periodically.
//   Pending intensity changes are inserted between frames.
//   Sits between the host register interface and led_driver.
//   Drives the driver's start strobe and command word; tracks its READY line.
// PARAMETERS
//   REFRESH_DIV  50000  idle cycles between frame_done and next frame (>=1)
//   ACK_TIMEOUT  64     cycles to wait for READY low after START before re-issuing START
//   INIT_INT     4'h8   intensity sent in init sequence
//   SCAN_LIMIT   3'd7   scan-limit field sent in init sequence
// PORTS
//   in_clk          in   1   system clock, rising edge
//   in_rst          in   1   asynchronous active-high reset
//   in_wr_en        in   1   host row write strobe
//   in_wr_row       in   3   row index 0..7
//   in_wr_data      in   8   row pixel data
//   in_int_en       in   1   host intensity update strobe
//   in_int_val      in   4   new intensity
//   in_IR_READY     in   1   driver idle/done (high = idle)
//   out_IR_START    out  1   one-cycle start strobe to driver
//   out_WORD        out  16  command word {addr[7:0], data[7:0]}
//   out_busy        out  1   high while a word is in flight
//   out_init_done   out  1   sticky high once init list is sent
//   out_frame_done  out  1   one-cycle pulse after row 7 completes
// BEHAVIOUR
//   Reset (async, in_rst=1)
//   - All outputs 0; row regs 8'h00; state INIT; init idx 0; int_pending 0.
//   - Reset mid-transfer aborts immediately; there is no drain.
//   Init list, in order
//   - 0x0C01, 0x0900, 0x0B00|SCAN_LIMIT, 0x0A00|INIT_INT, 0x0F00.
//   Row word
//   - {8'(row+1), row_reg[row]}; rows are sent 0..7.
//   Intensity word
//   - 0x0A00|int_latched.
//   FSM states
//   - LOAD: select next word and latch it into out_WORD.
//   - START: out_IR_START=1 for exactly one cycle; out_busy=1.
//   - WAIT_ACK: wait for in_IR_READY=0.
//       - Timeout after ACK_TIMEOUT cycles -> back to START (same word).
//   - WAIT_DONE: wait for in_IR_READY=1 -> NEXT.
//   - NEXT: advance the init or row index.
//   - IDLE: count REFRESH_DIV cycles, then -> LOAD.
//   Transitions
//   - INIT list is sent first; after word 5, out_init_done=1 and rows start from row 0.
//   - Row 7 done -> out_frame_done pulse (1 cycle) -> IDLE.
//   - IDLE expiry with int_pending=1: send intensity word first, clear the flag, then row 0.
//   Word stability
//   - out_WORD is latched in LOAD.
//   - It is stable from START until WAIT_DONE exit.
//   Host writes
//   - Accepted every cycle, including mid-transfer.
//   - A word in flight keeps its latched value; the new data appears on the next refresh.
//   - in_int_en during INIT: sets int_pending; applied after the first frame.
//   - Latest in_int_val wins.
//   Simultaneous in_wr_en and in_int_en
//   - Both are captured.
//   - Writing the same row on consecutive cycles: the last write wins.
//   Latency
//   - LOAD->START: 1 cycle.
//   - READY rising in WAIT_DONE -> next START: 2 cycles (NEXT, LOAD).
//   READY glitch
//   - in_IR_READY high in WAIT_ACK is ignored (the driver has not yet accepted).
//   Counters
//   - Idle counter is ceil(log2(REFRESH_DIV+1)) bits wide; it saturates and does not wrap.
// TESTING (bench driver model: READY low 3 cycles after START, high 100 cycles later)
//   1. Release reset, no host activity:
//      -> 5 START pulses with WORDs 0C01, 0900, 0B07, 0A08, 0F00.
//      -> then out_init_done=1, then 0100..0800, then out_frame_done.
//   2. Write row 2 = 8'hA5 while row 2 is in flight:
//      -> current WORD stays 0300; next frame sends 03A5.
//   3. in_int_en with val 4'h3 mid-frame:
//      -> after IDLE, WORD 0A03 precedes 0100; sent only once.
//   4. Driver model never drops READY:
//      -> START re-pulses every ACK_TIMEOUT+1 cycles with the same WORD; out_busy stays 1.
//   5. Assert in_rst during WAIT_DONE of row 4:
//      -> all outputs 0 immediately; after release the init list restarts from 0C01.
//   6. Simultaneous in_wr_en (row 7 = 8'hFF) and in_int_en (4'hF):
//      -> next frame sends 0A0F then row 7 as 08FF.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// Command sequencer for a MAX7219-class SPI LED driver: sends the power-up init list,
// then refreshes the 8 row registers, and slots pending intensity updates in between frames.
module led_frame_sequencer #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter logic [3:0]  INIT_INT    = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT  = 3'd7
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_wr_en,
    input  logic [2:0]  in_wr_row,
    input  logic [7:0]  in_wr_data,
    input  logic        in_int_en,
    input  logic [3:0]  in_int_val,
    input  logic        in_IR_READY,
    output logic        out_IR_START,
    output logic [15:0] out_WORD,
    output logic        out_busy,
    output logic        out_init_done,
    output logic        out_frame_done
);
    localparam int IW = $clog2(REFRESH_DIV + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(REFRESH_DIV - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_IDLE
    } state_t;

    // Which word list is being walked: init list, single intensity word, or rows.
    typedef enum logic [1:0] {SEQ_INIT, SEQ_INT, SEQ_ROW} seq_t;

    state_t          state, state_n;
    seq_t            seq;
    logic [2:0]      idx;
    logic [7:0]      row_reg [8];
    logic [3:0]      int_latched;
    logic            int_pending;
    logic [AW-1:0]   ack_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [15:0]     word_sel;

    always_comb begin
        word_sel = 16'h0000;
        case (seq)
            SEQ_INIT: begin
                case (idx)
                    3'd0:    word_sel = 16'h0C01;
                    3'd1:    word_sel = 16'h0900;
                    3'd2:    word_sel = {8'h0B, 5'd0, SCAN_LIMIT};
                    3'd3:    word_sel = {8'h0A, 4'd0, INIT_INT};
                    3'd4:    word_sel = 16'h0F00;
                    default: word_sel = 16'h0000;
                endcase
            end
            SEQ_INT: word_sel = {8'h0A, 4'd0, int_latched};
            SEQ_ROW: word_sel = {{5'd0, idx} + 8'd1, row_reg[idx]};
            default: word_sel = 16'h0000;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= S_LOAD;
        else        state <= state_n;
    end

    always_comb begin
        state_n        = state;
        out_IR_START   = 1'b0;
        out_busy       = 1'b0;
        out_frame_done = 1'b0;
        case (state)
            S_LOAD:  state_n = S_START;
            S_START: begin
                out_IR_START = 1'b1;
                out_busy     = 1'b1;
                state_n      = S_WAIT_ACK;
            end
            // READY still high here means the driver has not taken the word yet.
            S_WAIT_ACK: begin
                out_busy = 1'b1;
                if (!in_IR_READY)            state_n = S_WAIT_DONE;
                else if (ack_cnt == ACK_LAST) state_n = S_START;
            end
            S_WAIT_DONE: begin
                out_busy = 1'b1;
                if (in_IR_READY) state_n = S_NEXT;
            end
            S_NEXT: begin
                if (seq == SEQ_ROW && idx == 3'd7) begin
                    out_frame_done = 1'b1;
                    state_n        = S_IDLE;
                end else begin
                    state_n = S_LOAD;
                end
            end
            S_IDLE:  if (idle_cnt == IDLE_LAST) state_n = S_LOAD;
            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_WORD      <= 16'h0000;
            out_init_done <= 1'b0;
            seq           <= SEQ_INIT;
            idx           <= 3'd0;
            int_latched   <= 4'd0;
            int_pending   <= 1'b0;
            ack_cnt       <= '0;
            idle_cnt      <= '0;
            for (int i = 0; i < 8; i++) row_reg[i] <= 8'h00;
        end else begin
            if (in_wr_en) row_reg[in_wr_row] <= in_wr_data;
            if (in_int_en) int_latched <= in_int_val;
            case (state)
                S_LOAD:     out_WORD <= word_sel;
                S_START:    ack_cnt <= '0;
                S_WAIT_ACK: if (ack_cnt != ACK_LAST) ack_cnt <= ack_cnt + AW'(1);
                S_NEXT: begin
                    case (seq)
                        SEQ_INIT: begin
                            if (idx == 3'd4) begin
                                out_init_done <= 1'b1;
                                seq           <= SEQ_ROW;
                                idx           <= 3'd0;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                        SEQ_INT: begin
                            seq <= SEQ_ROW;
                            idx <= 3'd0;
                        end
                        default: begin
                            if (idx == 3'd7) idle_cnt <= '0;
                            idx <= idx + 3'd1;
                        end
                    endcase
                end
                S_IDLE: begin
                    if (idle_cnt == IDLE_LAST) begin
                        seq         <= int_pending ? SEQ_INT : SEQ_ROW;
                        idx         <= 3'd0;
                        int_pending <= 1'b0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: ;
            endcase
            // A new request in the same cycle as the clear must survive it.
            if (in_int_en) int_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: a word-level model of the command stream plus
// hand-computed checks on the directed scenarios.
module tb_led_frame_sequencer;
    localparam int RD = 20;
    localparam int AT = 8;
    localparam int NEVER = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = 3'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        int_en = 1'b0;
    logic [3:0]  int_val = 4'd0;
    logic        ready;
    logic        start, busy, init_done, frame_done;
    logic [15:0] word;

    led_frame_sequencer #(.REFRESH_DIV(RD), .ACK_TIMEOUT(AT)) dut (
        .in_clk(clk), .in_rst(rst), .in_wr_en(wr_en), .in_wr_row(wr_row),
        .in_wr_data(wr_data), .in_int_en(int_en), .in_int_val(int_val),
        .in_IR_READY(ready), .out_IR_START(start), .out_WORD(word),
        .out_busy(busy), .out_init_done(init_done), .out_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Driver model: READY low 3 cycles after a START, back high 100 cycles later.
    bit drop_en = 1'b1;
    int dph = 0, dcnt = 0;
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ready = 1'b1; dph = 0;
            end else begin
                case (dph)
                    0: if (start && drop_en) begin dph = 1; dcnt = 0; end
                    1: begin dcnt++; if (dcnt == 3) begin ready = 1'b0; dph = 2; dcnt = 0; end end
                    default: begin dcnt++; if (dcnt == 100) begin ready = 1'b1; dph = 0; end end
                endcase
            end
        end
    end

    // Word-level model: position in the command program plus the host-visible state.
    logic [15:0] init_tab [5] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00};
    logic [7:0]  m_rows [8];
    logic [3:0]  m_int_val;
    bit          m_int_pend, m_after_idle, cur_int, in_flight, seen_low, exp_st;
    int          m_pos, cyc = 0, last_start, exp_start_cyc, fd_cyc, init_done_cyc;
    logic [15:0] cur_word;
    bit          p_wr, p_int;
    logic [2:0]  p_row;
    logic [7:0]  p_data;
    logic [3:0]  p_ival;
    logic [15:0] log_q [$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outputs", {12'd0, start, busy, init_done, frame_done, word}, 32'd0);
            m_pos = 0; m_after_idle = 0; m_int_pend = 0; m_int_val = 0;
            in_flight = 0; seen_low = 0; cur_int = 0; p_wr = 0; p_int = 0;
            for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
            exp_start_cyc = cyc + 2; fd_cyc = -1; init_done_cyc = NEVER; last_start = -100;
        end else begin
            exp_st = (cyc == exp_start_cyc) ||
                     (in_flight && !seen_low && cyc == last_start + AT + 1);
            chk("start", 32'(start), 32'(exp_st));
            chk("busy", 32'(busy), 32'(in_flight || exp_st));
            chk("frame_done", 32'(frame_done), 32'(cyc == fd_cyc));
            chk("init_done", 32'(init_done), 32'(cyc >= init_done_cyc));
            if (start) begin
                if (!in_flight) begin
                    if (m_pos < 5) begin
                        cur_word = init_tab[m_pos]; cur_int = 0;
                    end else if (m_after_idle && m_int_pend) begin
                        cur_word = {8'h0A, 4'h0, m_int_val}; cur_int = 1; m_int_pend = 0;
                    end else begin
                        cur_word = {8'(m_pos - 4), m_rows[m_pos - 5]}; cur_int = 0;
                    end
                    m_after_idle = 0;
                    log_q.push_back(cur_word);
                    in_flight = 1; seen_low = 0;
                end
                last_start = cyc;
            end
            if (in_flight) begin
                chk("word_stable", 32'(word), 32'(cur_word));
                if (!ready) seen_low = 1;
                else if (seen_low) begin
                    in_flight = 0;
                    if (cur_int) exp_start_cyc = cyc + 3;
                    else if (m_pos == 12) begin
                        fd_cyc = cyc + 1; m_pos = 5; m_after_idle = 1;
                        exp_start_cyc = cyc + 3 + RD;
                    end else begin
                        if (m_pos == 4) init_done_cyc = cyc + 2;
                        m_pos++;
                        exp_start_cyc = cyc + 3;
                    end
                end
            end
            // Host writes land one cycle after they are driven.
            if (p_wr) m_rows[p_row] = p_data;
            if (p_int) begin m_int_pend = 1; m_int_val = p_ival; end
            p_wr = wr_en; p_row = wr_row; p_data = wr_data; p_int = int_en; p_ival = int_val;
        end
    end

    task automatic host_wr(input bit we, input logic [2:0] r, input logic [7:0] d,
                           input bit ie, input logic [3:0] iv);
        @(posedge clk); #1;
        wr_en = we; wr_row = r; wr_data = d; int_en = ie; int_val = iv;
        @(posedge clk); #1;
        wr_en = 1'b0; int_en = 1'b0;
    endtask

    task automatic wait_word(input logic [15:0] w, input int budget, input string nm);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (start && word == w) hit = 1;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic wait_fd(input int budget, input string nm);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (frame_done) hit = 1;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    function automatic logic [15:0] log_at(input int k);
        return (log_q.size() > k) ? log_q[k] : 16'hDEAD;
    endfunction

    logic [15:0] frame1 [13] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00,
                                 16'h0100, 16'h0200, 16'h0300, 16'h0400,
                                 16'h0500, 16'h0600, 16'h0700, 16'h0800};

    initial begin
        bit hit, busy_ok;
        int n_st;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;

        // Power-up: init list then first frame
        wait_fd(3000, "t1_frame_done");
        @(posedge clk);
        chk("t1_log_size", 32'(log_q.size()), 32'd13);
        for (int i = 0; i < 13; i++) chk($sformatf("t1_word%0d", i), 32'(log_at(i)), 32'(frame1[i]));
        chk("t1_init_done", 32'(init_done), 32'd1);

        // Row 2 rewritten while in flight; intensity requested mid-frame
        wait_word(16'h0300, 2000, "t2_row2_start");
        repeat (5) @(negedge clk);
        host_wr(1, 3'd2, 8'hA5, 0, 4'h0);
        @(negedge clk);
        chk("t2_word_hold", 32'(word), 32'h0300);
        wait_word(16'h0500, 2000, "t3_row4_start");
        host_wr(0, 3'd0, 8'h00, 1, 4'h3);
        wait_fd(2000, "t2_frame2_done");
        log_q.delete();
        wait_fd(2000, "t3_frame3_done");
        @(posedge clk);
        chk("t3_log_size", 32'(log_q.size()), 32'd9);
        chk("t3_int_first", 32'(log_at(0)), 32'h0A03);
        chk("t3_row0_after", 32'(log_at(1)), 32'h0100);
        chk("t2_row2_new", 32'(log_at(3)), 32'h03A5);
        log_q.delete();

        // Simultaneous row 7 and intensity write while row 7 is in flight
        wait_word(16'h0800, 2000, "t6_row7_start");
        repeat (5) @(negedge clk);
        host_wr(1, 3'd7, 8'hFF, 1, 4'hF);
        @(negedge clk);
        chk("t6_word_hold", 32'(word), 32'h0800);
        wait_fd(2000, "t3_frame4_done");
        @(posedge clk);
        chk("t3_int_once_size", 32'(log_q.size()), 32'd8);
        chk("t3_int_once_first", 32'(log_at(0)), 32'h0100);
        log_q.delete();
        wait_fd(2000, "t6_frame5_done");
        @(posedge clk);
        chk("t6_log_size", 32'(log_q.size()), 32'd9);
        chk("t6_int_first", 32'(log_at(0)), 32'h0A0F);
        chk("t6_row7", 32'(log_at(8)), 32'h08FF);

        // Driver never acknowledges: START repeats every AT+1 cycles
        #1 drop_en = 1'b0;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (start) hit = 1;
        end
        chk("t4_first_start", 32'(hit), 32'd1);
        n_st = 0; busy_ok = 1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (start) n_st++;
            if (!busy) busy_ok = 0;
        end
        chk("t4_restarts", 32'(n_st), 32'd4);
        chk("t4_busy_held", 32'(busy_ok), 32'd1);
        chk("t4_word", 32'(word), 32'h0100);
        @(posedge clk); #1 drop_en = 1'b1;

        // Reset during WAIT_DONE of row 4
        wait_word(16'h0500, 1500, "t5_row4_start");
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (!ready) hit = 1;
        end
        chk("t5_ready_low", 32'(hit), 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_word", 32'(word), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_init_done", 32'(init_done), 32'h0);
        log_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_word(16'h0C01, 5, "t5_restart");
        @(posedge clk);
        chk("t5_log_size", 32'(log_q.size()), 32'd1);
        chk("t5_first_word", 32'(log_at(0)), 32'h0C01);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
